// File: rtl/hdc_pkg.sv
// Shared constants and types for the sparse HDC encoder datapath.
package hdc_pkg;

    localparam int unsigned HV_DIM      = 1024;
    localparam int unsigned CH_PER_PACK = 62;
    localparam int unsigned NUM_CH      = 617;
    localparam int unsigned CNT_W       = $clog2(NUM_CH + 1);

    typedef logic [HV_DIM-1:0] hv_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        THRESH = 2'd2,
        OUTPUT = 2'd3
    } bnd_state_t;

endpackage

// File: rtl/enc_bit_counter.sv
// One hypervector dimension: masked popcount of a pack column, saturating
// accumulator, and the threshold compare feeding the sample bit.
module enc_bit_counter #(
    parameter int unsigned CH_PER_PACK = hdc_pkg::CH_PER_PACK,
    parameter int unsigned CNT_W       = hdc_pkg::CNT_W
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic [CH_PER_PACK-1:0] bits_i,
    input  logic [CH_PER_PACK-1:0] mask_i,
    input  logic [CNT_W-1:0]       thr_i,
    output logic                   ge_o
);
    localparam int unsigned PC_W  = $clog2(CH_PER_PACK + 1);
    localparam int unsigned SUM_W = ((PC_W > CNT_W) ? PC_W : CNT_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [PC_W-1:0]  pc;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        pc = '0;
        for (int unsigned i = 0; i < CH_PER_PACK; i++) begin
            pc = pc + PC_W'(bits_i[i] & mask_i[i]);
        end
        sum = SUM_W'(cnt_q) + SUM_W'(pc);
    end

    // Sum is one bit wider than either operand so overflow is visible before clamping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (sum > CNT_MAX) ? '1 : sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ge_o = (cnt_q >= thr_i);

endmodule

// File: rtl/enc_bundler.sv
// Bundles packs of shifted channel hypervectors into one thresholded sparse
// sample hypervector, held under a valid/ready handshake.
module enc_bundler #(
    parameter int unsigned HV_DIM      = hdc_pkg::HV_DIM,
    parameter int unsigned CH_PER_PACK = hdc_pkg::CH_PER_PACK,
    parameter int unsigned NUM_CH      = hdc_pkg::NUM_CH,
    parameter int unsigned CNT_W       = $clog2(NUM_CH + 1)
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   start_bundling,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [CH_PER_PACK-1:0] ch_mask,
    input  logic [HV_DIM-1:0]      pack_hv [0:CH_PER_PACK-1],
    input  logic [CNT_W-1:0]       threshold,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [HV_DIM-1:0]      sample_hv,
    output logic                   busy
);
    import hdc_pkg::*;

    bnd_state_t        state_q, state_d;
    logic [CNT_W-1:0]  thr_q, thr_d;
    logic [HV_DIM-1:0] hv_q, hv_d;
    logic [HV_DIM-1:0] ge;
    logic              accept;

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == OUTPUT);
    assign busy      = (state_q != IDLE);
    assign sample_hv = hv_q;
    assign accept    = in_valid && in_ready && !start_bundling;

    for (genvar d = 0; d < HV_DIM; d++) begin : g_dim
        logic [CH_PER_PACK-1:0] col;
        for (genvar i = 0; i < CH_PER_PACK; i++) begin : g_ch
            assign col[i] = pack_hv[i][d];
        end
        enc_bit_counter #(
            .CH_PER_PACK(CH_PER_PACK),
            .CNT_W      (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .nrst  (nrst),
            .clr_i (start_bundling),
            .en_i  (accept),
            .bits_i(col),
            .mask_i(ch_mask),
            .thr_i (thr_q),
            .ge_o  (ge[d])
        );
    end

    // Start overrides every state; a beat presented alongside it is dropped.
    always_comb begin
        state_d = state_q;
        thr_d   = thr_q;
        hv_d    = hv_q;
        if (start_bundling) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept && in_last) begin
                        state_d = THRESH;
                        thr_d   = threshold;
                    end
                end
                THRESH: begin
                    hv_d    = ge;
                    state_d = OUTPUT;
                end
                OUTPUT: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            thr_q   <= '0;
            hv_q    <= '0;
        end else begin
            state_q <= state_d;
            thr_q   <= thr_d;
            hv_q    <= hv_d;
        end
    end

endmodule

// File: tb/tb_enc_bundler.sv
// Scoreboard bench for enc_bundler on a reduced 8-dim, 4-slot, 3-bit-count configuration.
module tb_enc_bundler;

    localparam int HV  = 8;
    localparam int CH  = 4;
    localparam int NCH = 7;
    localparam int CW  = 3;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          nrst;
    logic          start_bundling;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [CH-1:0] ch_mask;
    logic [HV-1:0] pack_hv [0:CH-1];
    logic [CW-1:0] threshold;
    logic          out_valid;
    logic          out_ready;
    logic [HV-1:0] sample_hv;
    logic          busy;

    int            checks = 0;
    int            errors = 0;
    logic [HV-1:0] sb [$];
    int unsigned   mcnt [HV];
    logic [HV-1:0] exp_last;

    enc_bundler #(
        .HV_DIM     (HV),
        .CH_PER_PACK(CH),
        .NUM_CH     (NCH),
        .CNT_W      (CW)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .start_bundling(start_bundling),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_last       (in_last),
        .ch_mask       (ch_mask),
        .pack_hv       (pack_hv),
        .threshold     (threshold),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .sample_hv     (sample_hv),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output side: every handshake retires the oldest expected sample.
    always @(negedge clk) begin
        if (nrst && out_valid && out_ready) begin
            check("sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) check("sample_hv", sample_hv, sb.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int d = 0; d < HV; d++) mcnt[d] = 0;
    endtask

    task automatic do_start();
        start_bundling = 1'b1;
        step();
        start_bundling = 1'b0;
        clear_model();
    endtask

    // One accepted beat; on the last beat predicts the sample and checks latency.
    task automatic beat(input logic [CH*HV-1:0] hvf, input logic [CH-1:0] m,
                        input logic last, input logic [CW-1:0] thr);
        logic [HV-1:0] e;
        int unsigned   c;
        for (int i = 0; i < CH; i++) pack_hv[i] = hvf[i*HV +: HV];
        ch_mask   = m;
        in_last   = last;
        threshold = thr;
        in_valid  = 1'b1;
        check("in_ready", in_ready, 1);
        step();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        threshold = CW'($urandom);
        for (int i = 0; i < CH; i++) pack_hv[i] = HV'($urandom);
        for (int d = 0; d < HV; d++)
            for (int i = 0; i < CH; i++)
                if (m[i] && hvf[i*HV + d]) mcnt[d]++;
        if (last) begin
            for (int d = 0; d < HV; d++) begin
                c = (mcnt[d] > SAT) ? SAT : mcnt[d];
                e[d] = (c >= thr);
            end
            exp_last = e;
            sb.push_back(e);
            check("lat_thresh_valid", out_valid, 0);
            check("lat_thresh_busy", busy, 1);
            check("lat_thresh_inready", in_ready, 0);
            step();
            check("lat_out_valid", out_valid, 1);
        end
    endtask

    task automatic finish_output(input int hold);
        check("ov_pre", out_valid, 1);
        repeat (hold) begin
            step();
            check("hold_valid", out_valid, 1);
            check("hold_hv", sample_hv, exp_last);
            check("hold_inready", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("ov_drop", out_valid, 0);
        check("busy_idle", busy, 0);
        check("hv_keep", sample_hv, exp_last);
    endtask

    function automatic logic [CH*HV-1:0] rep(input logic [HV-1:0] v);
        return {CH{v}};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        nrst = 1'b0; start_bundling = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        ch_mask = '0; threshold = '0; out_ready = 1'b0;
        for (int i = 0; i < CH; i++) pack_hv[i] = '0;
        clear_model();
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_sample_hv", sample_hv, 0);
        nrst = 1'b1;
        step();

        // in_valid outside ACCUM has no effect
        in_valid = 1'b1; in_last = 1'b1; ch_mask = '1;
        for (int i = 0; i < CH; i++) pack_hv[i] = '1;
        step(); step();
        check("idle_busy", busy, 0);
        check("idle_inready", in_ready, 0);
        in_valid = 1'b0; in_last = 1'b0;

        // basic two-beat sample
        do_start();
        beat(rep(8'h0F), 4'b1111, 1'b0, 3'd1);
        beat(rep(8'h0F), 4'b1111, 1'b1, 3'd5);
        finish_output(0);

        // masking
        do_start();
        beat(rep(8'hFF), 4'b0011, 1'b1, 3'd3);
        finish_output(0);
        do_start();
        beat(rep(8'hFF), 4'b0011, 1'b1, 3'd2);
        finish_output(0);

        // backpressure
        do_start();
        beat({8'h12, 8'h34, 8'h56, 8'h78}, 4'b1111, 1'b1, 3'd1);
        finish_output(5);

        // abort mid-ACCUM; the beat coincident with start is dropped
        do_start();
        beat(rep(8'hFF), 4'b1111, 1'b0, 3'd0);
        for (int i = 0; i < CH; i++) pack_hv[i] = '1;
        ch_mask = '1; in_valid = 1'b1;
        do_start();
        in_valid = 1'b0;
        beat(rep(8'h01), 4'b1111, 1'b1, 3'd1);
        finish_output(1);

        // saturation and threshold bounds
        do_start();
        repeat (2) beat(rep(8'hFF), 4'b1111, 1'b0, 3'd0);
        beat(rep(8'hFF), 4'b1111, 1'b1, 3'd0);
        finish_output(0);
        do_start();
        repeat (2) beat(rep(8'hFF), 4'b1111, 1'b0, 3'd0);
        beat(rep(8'hFF), 4'b1111, 1'b1, 3'd7);
        finish_output(0);
        do_start();
        beat(rep(8'hFF), 4'b1111, 1'b0, 3'd0);
        beat(rep(8'hFF), 4'b0011, 1'b1, 3'd7);
        finish_output(0);
        do_start();
        beat(rep(8'hA5), 4'b0000, 1'b1, 3'd0);
        finish_output(0);

        // start during OUTPUT discards the held result
        do_start();
        beat(rep(8'h3C), 4'b1111, 1'b1, 3'd2);
        do_start();
        void'(sb.pop_back());
        check("restart_valid", out_valid, 0);
        check("restart_inready", in_ready, 1);
        beat(rep(8'hC3), 4'b0101, 1'b1, 3'd2);
        finish_output(2);

        // randomized samples
        for (int s = 0; s < 40; s++) begin
            do_start();
            n = $urandom_range(1, 4);
            for (int b = 0; b < n; b++) begin
                if ($urandom_range(0, 3) == 0) step();
                beat({$urandom, $urandom}, CH'($urandom), (b == n - 1), CW'($urandom));
            end
            finish_output($urandom_range(0, 3));
        end

        // asynchronous reset while a result is held
        do_start();
        beat(rep(8'hFF), 4'b1111, 1'b1, 3'd1);
        #2;
        nrst = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_sample_hv", sample_hv, 0);
        check("arst_busy", busy, 0);
        check("arst_in_ready", in_ready, 0);
        sb.delete();
        clear_model();
        @(negedge clk);
        nrst = 1'b1;
        step();
        do_start();
        beat(rep(8'h81), 4'b1000, 1'b1, 3'd1);
        finish_output(0);

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
